// File: rtl/search_pkg.sv
// Shared types and widths for the lookup_bit search pipeline.
package search_pkg;
    localparam int CLUSTER_N = 36;
    localparam int STAGE_N   = 8;
    localparam int KEY_W     = 72;
    localparam int ADDR_W    = 9;
    localparam int STAGE_W   = 3;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_e;

    function automatic logic [STAGE_N-1:0] stage_onehot(input logic [STAGE_W-1:0] stage);
        return STAGE_N'(1) << stage;
    endfunction
endpackage

// File: rtl/upd_starve_cnt.sv
// Counts consecutive key grants while an update waits; raises force_upd at the limit.
module upd_starve_cnt #(
    parameter int MAX_RUN = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic upd_valid,
    input  logic key_grant,
    input  logic upd_grant,
    output logic force_upd
);
    localparam int CW = $clog2(MAX_RUN + 1);

    logic [CW-1:0] run_cnt_q, run_cnt_d;

    assign force_upd = (run_cnt_q == CW'(MAX_RUN));

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (!upd_valid || upd_grant)
            run_cnt_d = '0;
        else if (key_grant && !force_upd)
            run_cnt_d = run_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) run_cnt_q <= '0;
        else       run_cnt_q <= run_cnt_d;
    end
endmodule

// File: rtl/lookup_update_arbiter.sv
// Arbitrates the shared lookup_bit RAM port between the key stream and rule-update commands.
// Keys win unless an update has been starved for MAX_KEY_RUN grants; reads wait for return or timeout.
module lookup_update_arbiter
    import search_pkg::*;
#(
    parameter int CLUSTER_N   = search_pkg::CLUSTER_N,
    parameter int MAX_KEY_RUN = 16,
    parameter int RD_TIMEOUT  = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              key_in_valid,
    input  logic [search_pkg::KEY_W-1:0]      key_in,
    output logic                              key_ready,
    input  logic                              upd_valid,
    input  logic                              upd_rd,
    input  logic [search_pkg::STAGE_W-1:0]    upd_stage,
    input  logic [search_pkg::ADDR_W-1:0]     upd_addr,
    input  logic [CLUSTER_N-1:0]              upd_data,
    output logic                              upd_ready,
    output logic                              lu_key_valid,
    output logic [search_pkg::KEY_W-1:0]      lu_key,
    output logic [search_pkg::STAGE_N-1:0]    set_valid,
    output logic [search_pkg::STAGE_N-1:0]    read_valid,
    output logic [search_pkg::ADDR_W-1:0]     addr,
    output logic [CLUSTER_N-1:0]              set_data,
    input  logic [search_pkg::STAGE_N-1:0]    data_out_valid,
    input  logic [search_pkg::STAGE_N*CLUSTER_N-1:0] data_out,
    output logic                              rd_resp_valid,
    output logic [CLUSTER_N-1:0]              rd_resp_data,
    output logic                              rd_resp_err
);
    state_e               state_q, state_d;
    logic [3:0]           to_cnt_q, to_cnt_d;
    logic [STAGE_W-1:0]   rd_stage_q, rd_stage_d;
    logic                 lu_key_valid_q, lu_key_valid_d;
    logic [KEY_W-1:0]     lu_key_q, lu_key_d;
    logic [STAGE_N-1:0]   set_valid_q, set_valid_d;
    logic [STAGE_N-1:0]   read_valid_q, read_valid_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CLUSTER_N-1:0] set_data_q, set_data_d;

    logic                 force_upd;
    logic                 upd_grant, key_grant, wr_grant, rd_grant;
    logic                 rd_hit, rd_to;
    logic [CLUSTER_N-1:0] rd_slice;

    assign rd_slice = data_out[rd_stage_q*CLUSTER_N +: CLUSTER_N];

    upd_starve_cnt #(.MAX_RUN(MAX_KEY_RUN)) u_starve (
        .clk       (clk),
        .reset     (reset),
        .upd_valid (upd_valid),
        .key_grant (key_grant),
        .upd_grant (upd_grant),
        .force_upd (force_upd)
    );

    // Grant logic is combinational; it is forced quiet while reset is held.
    always_comb begin
        upd_grant = 1'b0;
        key_ready = 1'b0;
        if (!reset) begin
            if (state_q == IDLE) begin
                upd_grant = upd_valid && (!key_in_valid || force_upd);
                key_ready = !upd_grant;
            end else begin
                key_ready = key_in_valid;
            end
        end
        upd_ready = upd_grant;
        key_grant = key_in_valid && key_ready;
        wr_grant  = upd_grant && !upd_rd;
        rd_grant  = upd_grant && upd_rd;
    end

    // Read completion: a matching return beats a coincident timeout.
    always_comb begin
        rd_hit        = !reset && (state_q == RD_WAIT) && data_out_valid[rd_stage_q];
        rd_to         = !reset && (state_q == RD_WAIT) && (to_cnt_q == 4'(RD_TIMEOUT));
        rd_resp_valid = rd_hit || rd_to;
        rd_resp_err   = rd_to && !rd_hit;
        rd_resp_data  = rd_hit ? rd_slice : '0;
    end

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        rd_stage_d = rd_stage_q;
        case (state_q)
            IDLE: begin
                if (rd_grant) begin
                    state_d    = RD_WAIT;
                    to_cnt_d   = '0;
                    rd_stage_d = upd_stage;
                end
            end
            RD_WAIT: begin
                if (rd_hit || rd_to) state_d  = IDLE;
                else                 to_cnt_d = to_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lu_key_valid_d = key_grant;
        lu_key_d       = key_grant ? key_in : lu_key_q;
        set_valid_d    = wr_grant ? stage_onehot(upd_stage) : '0;
        read_valid_d   = rd_grant ? stage_onehot(upd_stage) : '0;
        addr_d         = upd_grant ? upd_addr : addr_q;
        set_data_d     = wr_grant ? upd_data : set_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            to_cnt_q       <= '0;
            rd_stage_q     <= '0;
            lu_key_valid_q <= 1'b0;
            lu_key_q       <= '0;
            set_valid_q    <= '0;
            read_valid_q   <= '0;
            addr_q         <= '0;
            set_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            to_cnt_q       <= to_cnt_d;
            rd_stage_q     <= rd_stage_d;
            lu_key_valid_q <= lu_key_valid_d;
            lu_key_q       <= lu_key_d;
            set_valid_q    <= set_valid_d;
            read_valid_q   <= read_valid_d;
            addr_q         <= addr_d;
            set_data_q     <= set_data_d;
        end
    end

    assign lu_key_valid = lu_key_valid_q;
    assign lu_key       = lu_key_q;
    assign set_valid    = set_valid_q;
    assign read_valid   = read_valid_q;
    assign addr         = addr_q;
    assign set_data     = set_data_q;
endmodule
